// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit, common-anode 7-segment
//   display. A CPU-writable 16-bit display port (req/ack handshake) is shown
//   when non-zero, otherwise the RAM-supplied value is shown. The source and
//   port updates only take effect at frame boundaries, so one frame never
//   mixes old and new digits.
//
//   Optional feature macro: HEX_BLINK_EN (adds blink_en input and a frame
//   counter that periodically force-blanks the anodes).
//
// Ports
//   clk         clock
//   reset       synchronous, active-high reset
//   wr_req      CPU write request, held high until wr_ack
//   wr_data     value for the display port, sampled when the request is accepted
//   wr_ack      one-cycle pulse: write committed to the port
//   ram_val     fallback display value, sampled at the frame boundary
//   seg         segments, active-low, bit0=a .. bit6=g
//   an          digit anodes, active-low one-hot; an[0] = least significant nibble
//   frame_tick  one-cycle pulse, the cycle after a frame boundary
//   blink_en    blink enable (HEX_BLINK_EN builds only)
module hex_scan_ctrl #(
  parameter logic [15:0] CLK_DIV      = 16'd50000,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_req,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  input  logic [15:0] ram_val,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
`ifdef HEX_BLINK_EN
  ,
  input  logic        blink_en
`endif
);

  typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] port_q, port_d;
  logic [15:0] pending_q, pending_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        wr_ack_q, wr_ack_d;
  logic        frame_tick_q, frame_tick_d;
  logic        slot_tick, fb, blank;

`ifdef HEX_BLINK_EN
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;
`else
  logic unused_blink_cfg;
  always_comb unused_blink_cfg = (BLINK_FRAMES == 0);
`endif

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    slot_tick = (cnt_q == CLK_DIV - 16'd1);
    fb        = slot_tick && (idx_q == 2'd3);
    cnt_d     = slot_tick ? '0 : cnt_q + 16'd1;
    idx_d     = slot_tick ? idx_q + 2'd1 : idx_q;

    state_d   = state_q;
    pending_d = pending_q;
    port_d    = port_q;
    case (state_q)
      IDLE: if (wr_req) begin
        pending_d = wr_data;
        state_d   = PEND;
      end
      PEND: if (fb) begin
        port_d  = pending_q;
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Source choice uses the port value committed on this same edge, so a
    // write and the frame that first shows it are aligned.
    shadow_d = shadow_q;
    if (fb) shadow_d = (port_d != '0) ? port_d : ram_val;

`ifdef HEX_BLINK_EN
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (fb) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    blank = blink_en && phase_q;
`else
    blank = 1'b0;
`endif

    // First cycle of each slot is blanked to hide segment transitions.
    an_d         = ((cnt_q == '0) || blank) ? '1 : ~(4'b0001 << idx_q);
    seg_d        = hex7(shadow_q[{idx_q, 2'b00} +: 4]);
    wr_ack_d     = (state_d == ACK);
    frame_tick_d = fb;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      port_q       <= '0;
      pending_q    <= '0;
      shadow_q     <= '0;
      an_q         <= '1;
      seg_q        <= '1;
      wr_ack_q     <= 1'b0;
      frame_tick_q <= 1'b0;
`ifdef HEX_BLINK_EN
      fcnt_q       <= '0;
      phase_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      port_q       <= port_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      wr_ack_q     <= wr_ack_d;
      frame_tick_q <= frame_tick_d;
`ifdef HEX_BLINK_EN
      fcnt_q       <= fcnt_d;
      phase_q      <= phase_d;
`endif
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign wr_ack     = wr_ack_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
module tb_hex_scan_ctrl;
  localparam logic [15:0] CD = 16'd4;
  localparam int unsigned BF = 2;
  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_req = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_ack;
  logic [15:0] ram_val = 16'h1234;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;
`ifdef HEX_BLINK_EN
  logic        blink_en = 1'b0;
`endif

  hex_scan_ctrl #(.CLK_DIV(CD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_data(wr_data),
    .wr_ack(wr_ack), .ram_val(ram_val), .seg(seg), .an(an),
    .frame_tick(frame_tick)
`ifdef HEX_BLINK_EN
    , .blink_en(blink_en)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       ft;
    logic       ack;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: time since reset determines the scan position; the
  // display content is tracked as abstract port/pending/shown values.
  int unsigned t, pos, idx, nfb;
  logic [15:0] m_port, m_pend, m_shown, pn;
  bit          m_valid = 0, m_busy, m_ackcyc, fb, blk;
  logic [3:0]  oh;
  obs_t        e;

  always @(posedge clk) begin
    if (reset) begin
      t = 0; nfb = 0; m_port = '0; m_pend = '0; m_shown = '0;
      m_busy = 0; m_ackcyc = 0; m_valid = 1;
      e = '{an: 4'hF, seg: 7'h7F, ft: 1'b0, ack: 1'b0};
      exp_q.push_back(e);
    end else if (m_valid) begin
      pos = t % CD;
      idx = (t / CD) % 4;
      fb  = (pos == CD - 1) && (idx == 3);
`ifdef HEX_BLINK_EN
      blk = blink_en && (((nfb / BF) % 2) == 1);
`else
      blk = 0;
`endif
      oh     = 4'b0001 << idx;
      e.an   = (pos == 0 || blk) ? 4'hF : ~oh;
      e.seg  = HEX[m_shown[4*idx +: 4]];
      e.ft   = fb;
      e.ack  = m_busy && fb;
      pn = (m_busy && fb) ? m_pend : m_port;
      if (fb) m_shown = (pn != 0) ? pn : ram_val;
      if (m_ackcyc) m_ackcyc = 0;
      else if (m_busy) begin
        if (fb) begin m_port = m_pend; m_busy = 0; m_ackcyc = 1; end
      end else if (wr_req) begin
        m_pend = wr_data; m_busy = 1;
      end
      if (fb) nfb++;
      t++;
      exp_q.push_back(e);
    end
  end

  // Monitor: every cycle the DUT presents a display/status sample.
  obs_t got, ex;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ex  = exp_q.pop_front();
      got = '{an: an, seg: seg, ft: frame_tick, ack: wr_ack};
      total++;
      if (got !== ex) begin
        bad++;
        $display("FAIL outputs @%0t: an=%b exp %b seg=%b exp %b frame_tick=%b exp %b wr_ack=%b exp %b",
                 $time, got.an, ex.an, got.seg, ex.seg, got.ft, ex.ft, got.ack, ex.ack);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input logic [15:0] d);
    bit seen;
    seen = 0;
    wr_req  = 1'b1;
    wr_data = d;
    for (int i = 0; i < 4*CD + 8; i++) begin
      @(posedge clk); #1;
      if (wr_ack) begin seen = 1; break; end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL ack_timeout: wr_ack=0 required 1 within %0d cycles (data %h)", 4*CD + 8, d);
    end
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  initial begin
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(40);

    wait_cycles(6);
    do_write(16'hBEEF);
    wait_cycles(20);

    do_write(16'h0000);
    wait_cycles(21);
    ram_val = 16'h5678;
    wait_cycles(40);

    wait_cycles(3);
    wr_req = 1'b1; wr_data = 16'hA5A5;
    wait_cycles(2);
    reset = 1'b1; wr_req = 1'b0;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(40);

    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: ram_val = 16'($urandom);
        3, 4, 5: do_write(($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
        6: begin
          reset = 1'b1;
          wait_cycles($urandom_range(1, 2));
          reset = 1'b0;
        end
`ifdef HEX_BLINK_EN
        7: blink_en = ~blink_en;
`endif
        default: wr_data = 16'($urandom);
      endcase
      wait_cycles($urandom_range(0, 7));
    end

    wait_cycles(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
